// File: rtl/periph_bus_decoder.sv
// periph_bus_decoder
//   Connects the CPU data port to four memory-mapped slaves. Each access is
//   steered to a slave by address[31:28]. The decoder then holds that slave's
//   strobe until the slave responds, and returns a single response pulse to the CPU.
//   Accesses to an unmapped address, and accesses whose slave never answers,
//   complete with an error instead of stalling the core.
module periph_bus_decoder #(
  parameter logic [3:0] SLV0_ID = 4'h0,
  parameter logic [3:0] SLV1_ID = 4'h1,
  parameter logic [3:0] SLV2_ID = 4'h2,
  parameter logic [3:0] SLV3_ID = 4'h3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_read,
  input  logic         cpu_write,
  input  logic [31:0]  cpu_address,
  input  logic [31:0]  cpu_write_data,
  output logic [31:0]  cpu_read_data,
  output logic         cpu_response,
  output logic         cpu_error,
  output logic         busy,
  output logic [3:0]   slv_read,
  output logic [3:0]   slv_write,
  output logic [31:0]  slv_address,
  output logic [31:0]  slv_write_data,
  input  logic [127:0] slv_read_data,
  input  logic [3:0]   slv_response
);

  localparam int NUM_SLV = 4;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // The access latched at acceptance. The address and data are kept in the
  // slv_* output registers themselves.
  typedef struct packed {
    logic       wr;
    logic       mapped;
    logic [1:0] sel;
  } req_t;

  state_t state, state_nxt;
  req_t   req, req_nxt;
  logic [7:0] tmo_cnt, tmo_cnt_nxt;

  logic [NUM_SLV-1:0][3:0]  slv_id;
  logic [NUM_SLV-1:0][31:0] rdata_arr;
  logic       dec_hit;
  logic [1:0] dec_sel;
  logic       accept;
  logic       sel_resp;
  logic [31:0] sel_rdata;
  logic       tmo_hit;

  logic [31:0] cpu_read_data_nxt;
  logic        cpu_response_nxt;
  logic        cpu_error_nxt;
  logic        busy_nxt;
  logic [3:0]  slv_read_nxt;
  logic [3:0]  slv_write_nxt;
  logic [31:0] slv_address_nxt;
  logic [31:0] slv_write_data_nxt;

  assign slv_id    = {SLV3_ID, SLV2_ID, SLV1_ID, SLV0_ID};
  assign rdata_arr = slv_read_data;

  // Address decode. The scan runs from the highest slave index downward, so
  // when two slaves share an ID the lowest index is the one that wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = 2'd0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (cpu_address[31:28] == slv_id[i]) begin
        dec_hit = 1'b1;
        dec_sel = 2'(i);
      end
    end
  end

  // Only the selected slave's response and read data are looked at.
  assign accept    = (state == IDLE) && (cpu_read || cpu_write);
  assign sel_resp  = slv_response[req.sel];
  assign sel_rdata = rdata_arr[req.sel];
  assign tmo_hit   = (tmo_cnt + 8'd1) == TMO;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      req     <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      req     <= req_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // Next-state logic. An unmapped access still passes through one WAIT cycle,
  // but it drives no strobe. This gives every access the same two-cycle
  // latency to cpu_response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = WAIT;
      WAIT: if (!req.mapped || sel_resp || tmo_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: compute the value every output will hold next cycle, so
  // that all outputs leave the block straight from flops.
  always_comb begin
    req_nxt            = req;
    slv_address_nxt    = slv_address;
    slv_write_data_nxt = slv_write_data;
    slv_read_nxt       = '0;
    slv_write_nxt      = '0;
    cpu_read_data_nxt  = '0;
    cpu_response_nxt   = 1'b0;
    cpu_error_nxt      = 1'b0;
    busy_nxt           = (state_nxt != IDLE);
    tmo_cnt_nxt        = '0;

    if (accept) begin
      // When read and write are both asserted, the access is treated as a write.
      req_nxt.wr         = cpu_write;
      req_nxt.mapped     = dec_hit;
      req_nxt.sel        = dec_sel;
      slv_address_nxt    = cpu_address;
      slv_write_data_nxt = cpu_write_data;
    end

    if (state_nxt == WAIT && req_nxt.mapped) begin
      if (req_nxt.wr) slv_write_nxt[req_nxt.sel] = 1'b1;
      else            slv_read_nxt[req_nxt.sel]  = 1'b1;
    end

    if (state == WAIT && state_nxt == WAIT) tmo_cnt_nxt = tmo_cnt + 8'd1;

    if (state == WAIT && state_nxt == DONE) begin
      cpu_response_nxt = 1'b1;
      // A response that arrives in the same cycle as the timeout is still honoured.
      cpu_error_nxt    = !req.mapped || !sel_resp;
      if (req.mapped && sel_resp && !req.wr) cpu_read_data_nxt = sel_rdata;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_read_data  <= '0;
      cpu_response   <= 1'b0;
      cpu_error      <= 1'b0;
      busy           <= 1'b0;
      slv_read       <= '0;
      slv_write      <= '0;
      slv_address    <= '0;
      slv_write_data <= '0;
    end else begin
      cpu_read_data  <= cpu_read_data_nxt;
      cpu_response   <= cpu_response_nxt;
      cpu_error      <= cpu_error_nxt;
      busy           <= busy_nxt;
      slv_read       <= slv_read_nxt;
      slv_write      <= slv_write_nxt;
      slv_address    <= slv_address_nxt;
      slv_write_data <= slv_write_data_nxt;
    end
  end

endmodule

// File: tb/tb_periph_bus_decoder.sv
// tb_periph_bus_decoder
//   Directed vectors against periph_bus_decoder with TIMEOUT=4.
//   Slaves 0, 1 and 3 respond combinationally from their strobes.
//   Slave 2 never responds.
module tb_periph_bus_decoder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_address, cpu_write_data;
  logic [31:0]  cpu_read_data;
  logic         cpu_response, cpu_error, busy;
  logic [3:0]   slv_read, slv_write;
  logic [31:0]  slv_address, slv_write_data;
  logic [127:0] slv_read_data;
  logic [3:0]   slv_response;
  logic [3:0]   resp_en;
  logic [3:0]   spur;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign slv_read_data = {32'h3333_00C3, 32'h2222_0022, 32'h0000_005A, 32'h0000_1111};
  assign slv_response  = ((slv_read | slv_write) & resp_en) | spur;

  periph_bus_decoder #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .cpu_response   (cpu_response),
    .cpu_error      (cpu_error),
    .busy           (busy),
    .slv_read       (slv_read),
    .slv_write      (slv_write),
    .slv_address    (slv_address),
    .slv_write_data (slv_write_data),
    .slv_read_data  (slv_read_data),
    .slv_response   (slv_response)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request during the current cycle (N), then return in cycle N+1
  // with the request inputs released.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data);
    cpu_read       = rd;
    cpu_write      = wr;
    cpu_address    = addr;
    cpu_write_data = data;
    tick();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  int strb, rsp, s3;

  initial begin
    rst_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_address = '0; cpu_write_data = '0;
    resp_en = 4'b1011; spur = 4'b0000;
    tick(); tick();

    // Reset state
    chk("rst_rsp",   cpu_response, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_srd",   slv_read, 0);
    chk("rst_swr",   slv_write, 0);
    chk("rst_saddr", slv_address, 0);
    chk("rst_rdata", cpu_read_data, 0);
    rst_n = 1'b1;
    tick();

    // 1: write 0xA5 to slave 1
    issue(1'b0, 1'b1, 32'h1000_0004, 32'h0000_00A5);
    chk("t1_swr",   slv_write, 4'b0010);
    chk("t1_srd",   slv_read, 0);
    chk("t1_wdata", slv_write_data, 32'hA5);
    chk("t1_addr",  slv_address, 32'h1000_0004);
    chk("t1_busy",  busy, 1);
    chk("t1_rsp0",  cpu_response, 0);
    tick();
    chk("t1_rsp",   cpu_response, 1);
    chk("t1_err",   cpu_error, 0);
    chk("t1_swr2",  slv_write, 0);
    chk("t1_busy2", busy, 1);
    tick();
    chk("t1_rsp3",  cpu_response, 0);
    chk("t1_busy3", busy, 0);

    // 2: read slave 1, which returns 0x5A
    issue(1'b1, 1'b0, 32'h1000_0000, 32'h0);
    chk("t2_srd",   slv_read, 4'b0010);
    chk("t2_rd0",   cpu_read_data, 0);
    tick();
    chk("t2_rsp",   cpu_response, 1);
    chk("t2_rdata", cpu_read_data, 32'h5A);
    chk("t2_err",   cpu_error, 0);
    tick();
    chk("t2_rd3",   cpu_read_data, 0);

    // 3: unmapped read
    issue(1'b1, 1'b0, 32'hF000_0000, 32'h0);
    chk("t3_srd",   slv_read, 0);
    chk("t3_swr",   slv_write, 0);
    chk("t3_busy",  busy, 1);
    chk("t3_rsp0",  cpu_response, 0);
    tick();
    chk("t3_rsp",   cpu_response, 1);
    chk("t3_err",   cpu_error, 1);
    chk("t3_rdata", cpu_read_data, 0);
    tick();

    // 4: timeout on slave 2; responses from other slaves must be ignored
    spur = 4'b1011;
    issue(1'b1, 1'b0, 32'h2000_0000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_srd%0d", k), slv_read, 4'b0100);
      chk($sformatf("t4_rsp%0d", k), cpu_response, 0);
      tick();
    end
    spur = 4'b0000;
    chk("t4_srd_end", slv_read, 0);
    chk("t4_rsp",     cpu_response, 1);
    chk("t4_err",     cpu_error, 1);
    chk("t4_rdata",   cpu_read_data, 0);
    tick();

    // 5: requests while busy are dropped
    issue(1'b1, 1'b0, 32'h1000_0000, 32'h0);
    strb = 0; rsp = 0; s3 = 0;
    for (int k = 0; k < 6; k++) begin
      if (slv_read != 0) strb++;
      if (slv_read[3])   s3++;
      if (cpu_response)  rsp++;
      cpu_read    = (k < 2);
      cpu_address = 32'h3000_0000;
      tick();
    end
    cpu_read = 1'b0;
    chk("t5_strobes", strb, 1);
    chk("t5_resps",   rsp, 1);
    chk("t5_slv3",    s3, 0);

    // 6: reset during WAIT aborts the access without a response
    issue(1'b1, 1'b0, 32'h2000_0000, 32'h0);
    chk("t6_srd", slv_read, 4'b0100);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_srd0", slv_read, 0);
    chk("t6_busy", busy, 0);
    chk("t6_rsp",  cpu_response, 0);
    rsp = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (cpu_response) rsp++;
    end
    chk("t6_norsp", rsp, 0);
    issue(1'b1, 1'b0, 32'h3000_0008, 32'h0);
    chk("t6_srd3", slv_read, 4'b1000);
    tick();
    chk("t6_rsp2",  cpu_response, 1);
    chk("t6_rdata", cpu_read_data, 32'h3333_00C3);
    tick();

    // Read and write asserted together: the access is a write
    issue(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("rw_swr",   slv_write, 4'b0001);
    chk("rw_srd",   slv_read, 0);
    chk("rw_wdata", slv_write_data, 32'hDEAD_BEEF);
    tick();
    chk("rw_rsp",   cpu_response, 1);
    chk("rw_rdata", cpu_read_data, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
